// File: rtl/nn_dense_layer.sv
// Time-multiplexed fully-connected layer: y[j] = act(b[j] + sum x[i]*W[i][j]), LANES neurons per pass.
// Optional argmax tracker on the output stream is enabled with `define NN_DENSE_ARGMAX_EN.
module nn_dense_layer #(
  parameter  int N_IN   = 784,
  parameter  int N_OUT  = 30,
  parameter  int LANES  = 8,
  parameter  int DATA_W = 16,
  parameter  int FRAC_W = 8,
  parameter  int ACC_W  = 40,
  localparam int G      = (N_OUT + LANES - 1) / LANES,
  localparam int IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int W_AW   = (G * N_IN > 1) ? $clog2(G * N_IN) : 1,
  localparam int B_AW   = (G > 1) ? $clog2(G) : 1,
  localparam int O_AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      start,
  input  logic                      relu_en,
  output logic [IN_AW-1:0]          in_addr,
  input  logic [DATA_W-1:0]         in_data,
  output logic [W_AW-1:0]           w_addr,
  input  logic [LANES*DATA_W-1:0]   w_data,
  output logic [B_AW-1:0]           b_addr,
  input  logic [LANES*DATA_W-1:0]   b_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [O_AW-1:0]           out_idx,
  output logic                      busy,
  output logic                      done,
  output logic [O_AW-1:0]           pred_idx
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_BIAS  | bias/first-element addresses on the bus for the current group
  // S_MAC   | N_IN accumulate cycles, one input element per cycle
  // S_DRAIN | stream the group's valid lanes out under out_ready
  // S_DONE  | one-cycle done pulse

  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LAST_LANE = N_OUT - 1 - (G - 1) * LANES;

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [B_AW-1:0]  group_q;
  logic [LW-1:0]    lane_q;
  logic [IN_AW-1:0] mac_rem_q;
  logic             relu_q;
  logic [IN_AW-1:0] in_addr_q;
  logic [W_AW-1:0]  w_addr_q;
  logic [B_AW-1:0]  b_addr_q;

  logic signed [ACC_W-1:0] acc_q   [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];

  logic mac_first, mac_last, group_last, lane_last, fire;

  assign mac_first  = (mac_rem_q == IN_AW'(N_IN - 1));
  assign mac_last   = (mac_rem_q == '0);
  assign group_last = (group_q == B_AW'(G - 1));
  assign lane_last  = (lane_q == (group_last ? LW'(LAST_LANE) : LW'(LANES - 1)));
  assign fire       = (state_q == S_DRAIN) && out_ready;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_BIAS;
      end
      S_BIAS:  state_d = S_MAC;
      S_MAC:   if (mac_last) state_d = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && lane_last) state_d = group_last ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane MAC: the first element folds the bias in, aligned to the product's 2*FRAC_W scale.
  logic signed [DATA_W-1:0] x_s;
  assign x_s = in_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_W-1:0]   w_k, b_k;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, b_ext, bias_sh;
    assign w_k      = w_data[k*DATA_W +: DATA_W];
    assign b_k      = b_data[k*DATA_W +: DATA_W];
    assign prod     = x_s * w_k;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign b_ext    = {{(ACC_W-DATA_W){b_k[DATA_W-1]}}, b_k};
    assign bias_sh  = b_ext <<< FRAC_W;
    assign acc_nxt[k] = (mac_first ? bias_sh : acc_q[k]) + prod_ext;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      group_q   <= '0;
      lane_q    <= '0;
      mac_rem_q <= '0;
      relu_q    <= 1'b0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            relu_q    <= relu_en;
            group_q   <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            b_addr_q  <= '0;
          end
        end
        S_BIAS: begin
          mac_rem_q <= IN_AW'(N_IN - 1);
          lane_q    <= '0;
          in_addr_q <= in_addr_q + IN_AW'(1);
          w_addr_q  <= w_addr_q + W_AW'(1);
        end
        S_MAC: begin
          for (int k = 0; k < LANES; k++) acc_q[k] <= acc_nxt[k];
          in_addr_q <= in_addr_q + IN_AW'(1);
          w_addr_q  <= w_addr_q + W_AW'(1);
          if (!mac_last) mac_rem_q <= mac_rem_q - IN_AW'(1);
        end
        S_DRAIN: begin
          if (fire) begin
            if (!lane_last) begin
              lane_q <= lane_q + LW'(1);
            end else if (!group_last) begin
              group_q   <= group_q + B_AW'(1);
              b_addr_q  <= group_q + B_AW'(1);
              in_addr_q <= '0;
              w_addr_q  <= W_AW'((int'(group_q) + 1) * N_IN);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_addr = in_addr_q;
  assign w_addr  = w_addr_q;
  assign b_addr  = b_addr_q;

  // Round half up, saturate to DATA_W, then optional ReLU.
  function automatic logic [DATA_W-1:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                  input logic relu);
    logic signed [ACC_W-1:0] r;
    logic [DATA_W-1:0]       y;
    r = (a + RND) >>> FRAC_W;
    if (r > SAT_MAX)      y = SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN) y = SAT_MIN[DATA_W-1:0];
    else                  y = r[DATA_W-1:0];
    if (relu && y[DATA_W-1]) y = '0;
    return y;
  endfunction

  // Built only from registers, so it holds steady through any stall.
  assign out_data = post_proc(acc_q[lane_q], relu_q);
  assign out_idx  = O_AW'(int'(group_q) * LANES + int'(lane_q));

`ifdef NN_DENSE_ARGMAX_EN
  logic signed [DATA_W-1:0] max_val_q;
  logic                     have_max_q;
  logic [O_AW-1:0]          max_idx_q;
  logic signed [DATA_W-1:0] y_s;
  assign y_s = out_data;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      max_val_q  <= '0;
      have_max_q <= 1'b0;
      max_idx_q  <= '0;
    end else if (state_q == S_IDLE && start) begin
      have_max_q <= 1'b0;
      max_idx_q  <= '0;
    end else if (fire && (!have_max_q || y_s > max_val_q)) begin
      max_val_q  <= y_s;
      max_idx_q  <= out_idx;
      have_max_q <= 1'b1;
    end
  end

  assign pred_idx = max_idx_q;
`else
  assign pred_idx = '0;
`endif

endmodule
